// File: rtl/jtkcpu_stack_seq.sv
// Push/pull sequencer for register stacking: walks an 8-bit register mask one
// byte at a time, drives the memory controller's stack port and writes back SP.
module jtkcpu_stack_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        mem_busy,
    input  logic        start,
    input  logic        pull,
    input  logic        use_u,
    input  logic [7:0]  mask,
    input  logic [7:0]  cc,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  dp,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] u,
    input  logic [15:0] s,
    input  logic [15:0] pc,
    input  logic [7:0]  din,
    output logic [15:0] psh_addr,
    output logic        psh_dec,
    output logic        stack_busy,
    output logic [7:0]  psh_mux,
    output logic        pul_we,
    output logic [2:0]  pul_sel,
    output logic        pul_hi,
    output logic [7:0]  pul_dout,
    output logic        sp_we,
    output logic [15:0] sp_dout,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, PSH, PUL_ADR, PUL_DAT, DONE} state_t;

    state_t      state, next_state;
    logic [15:0] sp;
    logic [7:0]  msk;
    logic        pull_r, use_u_r, second;
    logic        advance;
    logic [2:0]  hi_idx, lo_idx, idx;
    logic        wide, last_byte;
    logic [7:0]  rest;
    logic [15:0] reg16;
    logic [7:0]  reg8, push_byte;

    assign advance = cen & ~mem_busy;

    // Push services the highest set bit, pull the lowest.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (msk[i])     hi_idx = 3'(i);
            if (msk[7 - i]) lo_idx = 3'(7 - i);
        end
        idx       = pull_r ? lo_idx : hi_idx;
        wide      = idx[2];
        last_byte = !wide || second;
        rest      = msk & ~(8'd1 << idx);
    end

    always_comb begin
        unique case (idx[1:0])
            2'd3:    reg16 = pc;
            2'd2:    reg16 = use_u_r ? s : u;
            2'd1:    reg16 = y;
            default: reg16 = x;
        endcase
        unique case (idx[1:0])
            2'd3:    reg8 = dp;
            2'd2:    reg8 = b;
            2'd1:    reg8 = a;
            default: reg8 = cc;
        endcase
        // 16-bit pushes go low byte first; `second` marks the high byte.
        push_byte = wide ? (second ? reg16[15:8] : reg16[7:0]) : reg8;
    end

    always_ff @(posedge clk) begin
        if (rst)          state <= IDLE;
        else if (advance) state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp      <= '0;
            msk     <= '0;
            pull_r  <= 1'b0;
            use_u_r <= 1'b0;
            second  <= 1'b0;
        end else if (advance) begin
            case (state)
                IDLE: if (start) begin
                    msk     <= mask;
                    pull_r  <= pull;
                    use_u_r <= use_u;
                    sp      <= use_u ? u : s;
                    second  <= 1'b0;
                end
                PSH, PUL_DAT: begin
                    sp <= (state == PSH) ? sp - 16'd1 : sp + 16'd1;
                    if (last_byte) begin
                        msk    <= rest;
                        second <= 1'b0;
                    end else begin
                        second <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) begin
                if (mask == '0) next_state = DONE;
                else            next_state = pull ? PUL_ADR : PSH;
            end
            PSH:     if (last_byte && rest == '0) next_state = DONE;
            PUL_ADR: next_state = PUL_DAT;
            PUL_DAT: next_state = (last_byte && rest == '0) ? DONE : PUL_ADR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        psh_addr   = '0;
        psh_dec    = 1'b0;
        stack_busy = 1'b0;
        psh_mux    = '0;
        pul_we     = 1'b0;
        pul_sel    = '0;
        pul_hi     = 1'b0;
        pul_dout   = '0;
        sp_we      = 1'b0;
        sp_dout    = '0;
        done       = 1'b0;
        case (state)
            PSH: begin
                stack_busy = 1'b1;
                psh_dec    = 1'b1;
                psh_addr   = sp;
                psh_mux    = push_byte;
            end
            PUL_ADR: begin
                stack_busy = 1'b1;
                psh_addr   = sp;
            end
            PUL_DAT: begin
                stack_busy = 1'b1;
                psh_addr   = sp;
                pul_we     = 1'b1;
                pul_sel    = idx;
                pul_hi     = wide && !second;
                pul_dout   = din;
            end
            DONE: begin
                sp_we   = 1'b1;
                done    = 1'b1;
                sp_dout = sp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Randomized bench for jtkcpu_stack_seq: a byte-level stack model predicts the
// push/pull traffic, final SP and step count of each sequence.
module tb_jtkcpu_stack_seq;

    logic        clk = 1'b0;
    logic        rst, cen, mem_busy, start, pull, use_u;
    logic [7:0]  mask, cc, a, b, dp, din;
    logic [15:0] x, y, u, s, pc;
    logic [15:0] psh_addr, sp_dout;
    logic        psh_dec, stack_busy, pul_we, pul_hi, sp_we, done;
    logic [7:0]  psh_mux, pul_dout;
    logic [2:0]  pul_sel;

    logic [7:0]  mem [65536];
    logic [63:0] obs;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign din = mem[psh_addr];
    assign obs = {7'd0, psh_addr, psh_dec, stack_busy, psh_mux, pul_we, pul_sel,
                  pul_hi, pul_dout, sp_we, sp_dout, done};

    jtkcpu_stack_seq dut (
        .clk(clk), .rst(rst), .cen(cen), .mem_busy(mem_busy), .start(start),
        .pull(pull), .use_u(use_u), .mask(mask), .cc(cc), .a(a), .b(b), .dp(dp),
        .x(x), .y(y), .u(u), .s(s), .pc(pc), .din(din),
        .psh_addr(psh_addr), .psh_dec(psh_dec), .stack_busy(stack_busy),
        .psh_mux(psh_mux), .pul_we(pul_we), .pul_sel(pul_sel), .pul_hi(pul_hi),
        .pul_dout(pul_dout), .sp_we(sp_we), .sp_dout(sp_dout), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] regval(input int bi, input logic uu);
        case (bi)
            7: return pc;
            6: return uu ? s : u;
            5: return y;
            4: return x;
            3: return {8'h00, dp};
            2: return {8'h00, b};
            1: return {8'h00, a};
            default: return {8'h00, cc};
        endcase
    endfunction

    function automatic logic [23:0] enc_pul(input logic [2:0] sel, input logic hi, input logic [7:0] d);
        return {11'd0, sel, hi, 1'b0, d};
    endfunction

    task automatic rand_regs();
        cc = 8'($urandom); a = 8'($urandom); b = 8'($urandom); dp = 8'($urandom);
        x = 16'($urandom); y = 16'($urandom); u = 16'($urandom);
        s = 16'($urandom); pc = 16'($urandom);
    endtask

    task automatic run_seq(input logic p, input logic uu, input logic [7:0] m,
                           input bit stall, input bit poke_start);
        logic [23:0] exp_q[$];
        logic [23:0] got_q[$];
        logic [15:0] msp, v;
        logic [63:0] prev_snap;
        bit          prev_adv, finished;
        int          nbytes, steps;

        msp = uu ? u : s;
        nbytes = 0;
        if (!p) begin
            for (int bi = 7; bi >= 0; bi--) if (m[bi]) begin
                v = regval(bi, uu);
                exp_q.push_back({msp, v[7:0]}); msp = msp - 16'd1; nbytes++;
                if (bi >= 4) begin
                    exp_q.push_back({msp, v[15:8]}); msp = msp - 16'd1; nbytes++;
                end
            end
        end else begin
            for (int bi = 0; bi < 8; bi++) if (m[bi]) begin
                if (bi >= 4) begin
                    exp_q.push_back(enc_pul(3'(bi), 1'b1, mem[msp])); msp = msp + 16'd1; nbytes++;
                end
                exp_q.push_back(enc_pul(3'(bi), 1'b0, mem[msp])); msp = msp + 16'd1; nbytes++;
            end
        end

        @(negedge clk);
        pull = p; use_u = uu; mask = m; start = 1'b1; cen = 1'b1; mem_busy = 1'b0;
        @(posedge clk);
        steps = 0; finished = 0; prev_adv = 1; prev_snap = '0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            mask = 8'($urandom);
            if (!prev_adv) chk("hold", obs, prev_snap);
            chk("busy_vs_done", {63'd0, stack_busy}, {63'd0, !done});
            if (stall) begin
                cen = ($urandom_range(0, 3) != 0);
                mem_busy = ($urandom_range(0, 3) == 0);
            end else begin
                cen = 1'b1; mem_busy = 1'b0;
            end
            if (cen && !mem_busy) begin
                steps++;
                if (psh_dec) got_q.push_back({psh_addr, psh_mux});
                if (pul_we)  got_q.push_back(enc_pul(pul_sel, pul_hi, pul_dout));
                if (done) begin
                    chk("sp_we", {63'd0, sp_we}, 64'd1);
                    chk("sp_dout", {48'd0, sp_dout}, {48'd0, msp});
                    finished = 1;
                end
            end
            prev_snap = obs;
            prev_adv = cen && !mem_busy;
            @(posedge clk);
        end
        if (!finished) chk("timeout_done", 64'd0, 64'd1);
        chk("steps", 64'(steps), p ? 64'(2 * nbytes + 1) : 64'(nbytes + 1));
        chk("event_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(p ? "pull_event" : "push_event", {40'd0, got_q[i]}, {40'd0, exp_q[i]});
        @(negedge clk);
        start = 1'b0; cen = 1'b1; mem_busy = 1'b0;
        chk("idle_outputs", obs, 64'd0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; cen = 1'b0; mem_busy = 1'b0; start = 1'b0; pull = 1'b0;
        use_u = 1'b0; mask = '0;
        rand_regs();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", obs, 64'd0);
        rst = 1'b0;

        // Directed cases
        s = 16'h1000; pc = 16'hC123; a = 8'h11; b = 8'h22;
        run_seq(1'b0, 1'b0, 8'h86, 0, 0);
        s = 16'h0FFC; mem[16'h0FFC] = 8'hAA; mem[16'h0FFD] = 8'hBB;
        run_seq(1'b1, 1'b0, 8'h06, 0, 0);
        s = 16'hFFFE; mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34;
        run_seq(1'b1, 1'b0, 8'h40, 0, 0);
        s = 16'h1234;
        run_seq(1'b0, 1'b0, 8'h00, 0, 0);
        s = 16'h0001; pc = 16'hBEEF;
        run_seq(1'b0, 1'b0, 8'h81, 1, 1);

        // Randomized sequences with stalls and stray start pulses
        for (int n = 0; n < 40; n++) begin
            rand_regs();
            run_seq(1'($urandom), 1'($urandom), 8'($urandom), 1, 1);
        end

        // Reset in the middle of a pull
        rand_regs();
        @(negedge clk);
        pull = 1'b1; use_u = 1'b0; mask = 8'h30; start = 1'b1; cen = 1'b1; mem_busy = 1'b0;
        @(posedge clk);
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (pul_we) seen = 1;
            else @(posedge clk);
        end
        chk("reach_pul_dat", {63'd0, seen}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_outputs", obs, 64'd0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_reset_quiet", {62'd0, done, sp_we}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
